id_inst_buffer: RTL and testbench
=================================

// Module: id_inst_buffer
// PURPOSE
//  Parametrised instruction queue between IF and ID. It replaces the one-entry stall latch in
//  front of the decoder with a DEPTH-entry FIFO of {pc, inst} pairs.
//  It holds fetched instructions while ID stalls, for example on a load-use bubble or a divider
//  wait. It also squashes wrong-path entries when ID resolves a taken branch, keeping exactly one
//  MIPS delay-slot instruction. ID consumes the head entry.
// PARAMETERS
//  DEPTH   4   entries; power of 2, >=2
//  PC_W    32  pc width
//  INST_W  32  instruction width
//  PTR_W   $clog2(DEPTH)  read/write pointer width (derived, not overridden)
// PORTS
//  clk        in   1        clock, all state on rising edge
//  rst        in   1        asynchronous active-high reset
//  flush      in   1        discard all entries (exception/redirect from later stage)
//  in_valid   in   1        IF presents an instruction
//  in_pc      in   PC_W     pc of pushed instruction
//  in_inst    in   INST_W   pushed instruction word
//  in_ready   out  1        buffer can accept; push = in_valid & in_ready
//  out_valid  out  1        head entry valid
//  out_pc     out  PC_W     head pc (0 when empty)
//  out_inst   out  INST_W   head instruction (0 when empty)
//  out_ready  in   1        ID accepts head this cycle (= ID not stalled); pop = out_valid & out_ready
//  br_taken   in   1        popped head is a taken branch/jump; qualified by pop
//  count      out  PTR_W+1  occupancy 0..DEPTH
//  ds_wait    out  1        in DS_WAIT state (delay slot not yet received)
// BEHAVIOUR
//  Reset:
//   - count=0, pointers=0, state=NORMAL, ds_wait=0, out_valid=0, out_pc=0, out_inst=0.
//   - in_ready is forced 0 while rst is high.
//  Storage and outputs:
//   - Storage is registers. The head is presented from storage (first-word fall-through).
//   - Push-to-out_valid latency is 1 cycle. There is no same-cycle bypass.
//   - in_ready = (count != DEPTH) & ~rst. It does not depend on pop, so there is no
//     out_ready->in_ready combinational path. When full, a push is refused even if a pop occurs.
//  Normal operation:
//   - Push writes at wptr; pop advances rptr. Both pointers wrap modulo DEPTH.
//   - Push and pop in the same cycle leave count unchanged.
//  Priority: flush > br_taken > normal.
//  flush:
//   - count:=0, rptr:=wptr, state:=NORMAL.
//   - A push in the same cycle is accepted (handshake completes) but discarded.
//   - A pop in the same cycle still completes: the head is consumed.
//  br_taken with pop (branch leaves buffer). Let n = count-1 = entries behind the head:
//   - n>=1: keep only entry rptr+1 (the delay slot); count:=1; any same-cycle push is
//     accepted-and-discarded; state stays NORMAL.
//   - n==0 with push: the pushed entry is the delay slot and is kept; count:=1; NORMAL.
//   - n==0 without push: count:=0, state:=DS_WAIT.
//   - br_taken without pop is ignored.
//  State DS_WAIT (ds_wait=1):
//   - The first accepted push is stored and the state returns to NORMAL.
//   - Pushes are never dropped in DS_WAIT, because IF has already redirected and the next
//     fetch is the delay slot.
//   - flush in DS_WAIT: state:=NORMAL, push discarded.
//  Reset mid-operation: asynchronous clear to reset values; contents are lost.
//  Width rules: count is PTR_W+1 bits. Full: count==DEPTH. Empty: count==0.
// TESTING
//  1. Reset release, push pc 0x100..0x10C (4 pushes), out_ready=0 ->
//     count=4, in_ready=0, out_pc=0x100; a 5th push is refused.
//  2. Full, out_ready=1, in_valid=1 with pc 0x110 ->
//     the pop occurs and the push is refused that cycle; count=3; the next cycle accepts 0x110.
//  3. Buffer holds 0x200,0x204,0x208,0x20C; pop 0x200 with br_taken=1 ->
//     next cycle count=1, out_pc=0x204; 0x208/0x20C are never output.
//  4. Buffer holds only 0x300; pop with br_taken, no push ->
//     ds_wait=1; push 0x304 then 0x400 -> outputs 0x304, 0x400 in order, ds_wait=0.
//  5. flush with a concurrent push of 0x500 while count=3 ->
//     next cycle count=0, out_valid=0, out_pc=0; 0x500 is never output.
//  6. Assert rst asynchronously mid-stream (count=2) ->
//     out_valid=0 and count=0 immediately, without a clock edge; in_ready=0 until rst falls.

Source files
------------

// File: rtl/id_inst_buffer.sv
// Instruction queue between IF and ID: DEPTH-entry FIFO of {pc, inst} pairs with
// flush and taken-branch squash that preserves exactly one delay-slot instruction.
module id_inst_buffer #(
  parameter  int DEPTH  = 4,
  parameter  int PC_W   = 32,
  parameter  int INST_W = 32,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  output logic              in_ready,
  output logic              out_valid,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  input  logic              out_ready,
  input  logic              br_taken,
  output logic [PTR_W:0]    count,
  output logic              ds_wait
);

  localparam logic [0:0]     NORMAL   = 1'b0;
  localparam logic [0:0]     DS_WAIT  = 1'b1;
  localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [PC_W-1:0]   pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [PTR_W-1:0]  wptr, rptr, rptr_p1, rptr_p2;
  logic [0:0]        state;
  logic              push, pop, br_pop, keep_ds, wr_en;

  assign in_ready  = (count != CNT_FULL) & ~rst;
  assign out_valid = (count != '0);
  assign out_pc    = out_valid ? pc_mem[rptr]   : '0;
  assign out_inst  = out_valid ? inst_mem[rptr] : '0;
  assign ds_wait   = (state == DS_WAIT);

  assign push    = in_valid & in_ready;
  assign pop     = out_valid & out_ready;
  assign br_pop  = pop & br_taken;
  assign keep_ds = br_pop & (count > CNT_ONE);
  assign rptr_p1 = rptr + PTR_ONE;
  assign rptr_p2 = rptr_p1 + PTR_ONE;

  // Pushes that are accepted but discarded (flush, or squashed behind a delay slot) never touch storage.
  assign wr_en = push & ~flush & ~keep_ds;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem[wptr]   <= in_pc;
      inst_mem[wptr] <= in_inst;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
      state <= NORMAL;
    end else if (flush) begin
      count <= '0;
      rptr  <= wptr;
      state <= NORMAL;
    end else if (br_pop) begin
      if (keep_ds) begin
        // Delay slot sits right behind the branch; truncate the queue after it.
        rptr  <= rptr_p1;
        wptr  <= rptr_p2;
        count <= CNT_ONE;
      end else if (push) begin
        rptr  <= wptr;
        wptr  <= wptr + PTR_ONE;
        count <= CNT_ONE;
      end else begin
        rptr  <= rptr_p1;
        count <= '0;
        state <= DS_WAIT;
      end
    end else begin
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr_p1;
      if (push && !pop)      count <= count + CNT_ONE;
      else if (pop && !push) count <= count - CNT_ONE;
      if (push) state <= NORMAL;
    end
  end

endmodule

// File: tb/tb_id_inst_buffer.sv
// Scoreboard bench for id_inst_buffer: a queue model of expected head entries is updated
// as stimulus is driven and compared against the DUT head every cycle.
module tb_id_inst_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, in_valid, in_ready, out_valid, out_ready, br_taken, ds_wait;
  logic [31:0] in_pc, in_inst, out_pc, out_inst;
  logic [2:0]  count;

  logic [31:0] q[$];
  logic        ds;
  int          passed = 0;
  int          total  = 0;

  id_inst_buffer #(.DEPTH(DEPTH), .PC_W(32), .INST_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_ready(in_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst), .out_ready(out_ready),
    .br_taken(br_taken), .count(count), .ds_wait(ds_wait)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[15:0], ~pc[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Drive one cycle, compare outputs against the model, then advance the model.
  task automatic step(input logic iv, input logic [31:0] pc, input logic ordy,
                      input logic br, input logic fl);
    logic push, pop;
    logic [31:0] tmp;
    in_valid = iv; in_pc = pc; in_inst = inst_of(pc);
    out_ready = ordy; br_taken = br; flush = fl;
    #1;
    check("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
    check("out_pc",    out_pc,   (q.size() != 0) ? q[0] : 32'h0);
    check("out_inst",  out_inst, (q.size() != 0) ? inst_of(q[0]) : 32'h0);
    check("count",     {29'b0, count}, q.size());
    check("in_ready",  {31'b0, in_ready}, {31'b0, q.size() != DEPTH});
    check("ds_wait",   {31'b0, ds_wait}, {31'b0, ds});
    push = iv && (q.size() != DEPTH);
    pop  = ordy && (q.size() != 0);
    if (fl) begin
      q.delete();
      ds = 1'b0;
    end else if (pop && br) begin
      void'(q.pop_front());
      if (q.size() >= 1) begin
        tmp = q[0];
        q.delete();
        q.push_back(tmp);
      end else if (push) begin
        q.push_back(pc);
      end else begin
        ds = 1'b1;
      end
    end else begin
      if (pop)  void'(q.pop_front());
      if (push) begin
        q.push_back(pc);
        ds = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int unsigned i = 0; i < DEPTH + 1; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0;
    out_ready = 1'b0; br_taken = 1'b0; ds = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'h0);
    check("rst_count",    {29'b0, count}, 32'h0);
    check("rst_out_pc",   out_pc, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Fill, refuse fifth push, then pop while full refuses the concurrent push.
    for (int unsigned i = 0; i < 4; i++) step(1'b1, 32'h100 + 4*i, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h110, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h110, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h110, 1'b0, 1'b0, 1'b0);
    drain();

    // Taken branch with entries behind it keeps only the delay slot.
    for (int unsigned i = 0; i < 4; i++) step(1'b1, 32'h200 + 4*i, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    drain();

    // Taken branch alone enters DS_WAIT; next pushes are kept in order.
    step(1'b1, 32'h300, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 32'h304, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h400, 1'b0, 1'b0, 1'b0);
    drain();

    // Taken branch alone with concurrent push: pushed entry is the delay slot.
    step(1'b1, 32'h600, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h604, 1'b1, 1'b1, 1'b0);
    drain();

    // Flush with concurrent push while count=3.
    for (int unsigned i = 0; i < 3; i++) step(1'b1, 32'h4F4 + 4*i, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h500, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Flush while in DS_WAIT discards the push and leaves DS_WAIT.
    step(1'b1, 32'h540, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 32'h544, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h548, 1'b0, 1'b0, 1'b0);
    drain();

    // Randomised mixed traffic exercising pointer wrap.
    for (int unsigned k = 0; k < 80; k++)
      step(1'($urandom_range(0, 3) != 0), 32'h1000 + 4*k, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 15) == 0));
    drain();

    // Asynchronous reset mid-stream with two entries held.
    step(1'b1, 32'h700, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h704, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    check("pre_rst_count", {29'b0, count}, 32'h2);
    rst = 1'b1;
    #1;
    check("arst_out_valid", {31'b0, out_valid}, 32'h0);
    check("arst_count",     {29'b0, count}, 32'h0);
    check("arst_in_ready",  {31'b0, in_ready}, 32'h0);
    @(posedge clk); #1;
    check("arst_hold_in_ready", {31'b0, in_ready}, 32'h0);
    rst = 1'b0;
    q.delete();
    ds = 1'b0;
    step(1'b1, 32'h800, 1'b0, 1'b0, 1'b0);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
